// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = x - y, one bit per clock, LSB first, through a single
// full-subtractor cell. A start request captures the operands; the result and the
// borrow out are registered on the edge that enters the one-cycle DONE state.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start_i  operation request, honoured only when not busy (IDLE or DONE)
//   x_i      minuend, captured on the accepting edge
//   y_i      subtrahend, captured on the accepting edge
//   busy_o   high while the bit-serial loop is running
//   done_o   one-cycle pulse when d_o/b_o have just been updated
//   d_o      difference modulo 2^WIDTH, holds until the next done
//   b_o      borrow out of bit WIDTH-1 (x < y unsigned), holds with d_o
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             b_o
);

  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              b_q, b_d;

  // Full-subtractor cell and the shifted working register it feeds.
  logic             xb, yb, diff_bit, bout;
  logic [WIDTH-1:0] work_shift;

  always_comb begin
    xb       = x_q[0];
    yb       = y_q[0];
    diff_bit = xb ^ yb ^ borrow_q;
    bout     = (~xb & yb) | (~(xb ^ yb) & borrow_q);

    // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    work_shift            = work_q >> 1;
    work_shift[WIDTH-1]   = diff_bit;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    work_d   = work_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    b_d      = b_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          x_d      = x_i;
          y_d      = y_i;
          work_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        x_d      = x_q >> 1;
        y_d      = y_q >> 1;
        work_d   = work_shift;
        borrow_d = bout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Publish straight from the cell so the result is valid while done_o is high.
          d_d     = work_shift;
          b_d     = bout;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      b_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      work_q   <= work_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      b_q      <= b_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign d_o    = d_q;
  assign b_o    = b_q;

endmodule
